// File: rtl/cnn_rd_arb.sv
// cnn_rd_arb: round-robin arbiter that shares one memory read port among the
// three CNN read clients (0 = picture, 1 = weights, 2 = bias). One transaction
// is outstanding at a time; the returned data is registered and broadcast,
// with a one-cycle cl_valid pulse to the served client.
//
// Optional feature: define CNN_RD_ARB_WDOG_EN to enable a watchdog. It bounds
// the time spent in ISSUE/WAIT to WDOG_CYCLES cycles and sets a sticky wdog_err.
// The WDOG_CYCLES parameter exists only when the macro is defined.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cl_req           per-client request, held until that client's cl_valid
//   cl_addr/cl_size  per-client address/size, client i in slice i
//   cl_gnt           one-hot grant, held from grant until RELEASE
//   cl_valid         one-cycle pulse to the served client
//   cl_data          registered return data (broadcast)
//   mem_req          memory read request
//   mem_start_addr   latched address of the granted client
//   mem_size_bytes   latched, clamped size of the granted client
//   mem_ack          memory accepted the request
//   mem_valid        memory read data valid
//   mem_data         memory read data
//   busy             high whenever the FSM is not idle
//   wdog_err         sticky watchdog error (0 when the watchdog is disabled)
module cnn_rd_arb #(
   parameter int unsigned ADDR_WIDTH      = 19,
   parameter int unsigned MEM_DATA_BUS    = 128,
   parameter int unsigned MAX_BYTES_TO_RD = 20,
   parameter int unsigned SIZE_WIDTH      = 5
`ifdef CNN_RD_ARB_WDOG_EN
   ,
   parameter int unsigned WDOG_CYCLES     = 255
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                cl_req,
   input  logic [3*ADDR_WIDTH-1:0]   cl_addr,
   input  logic [3*SIZE_WIDTH-1:0]   cl_size,
   output logic [2:0]                cl_gnt,
   output logic [2:0]                cl_valid,
   output logic [MEM_DATA_BUS-1:0]   cl_data,
   output logic                      mem_req,
   output logic [ADDR_WIDTH-1:0]     mem_start_addr,
   output logic [SIZE_WIDTH-1:0]     mem_size_bytes,
   input  logic                      mem_ack,
   input  logic                      mem_valid,
   input  logic [MEM_DATA_BUS-1:0]   mem_data,
   output logic                      busy,
   output logic                      wdog_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [1:0]              rr_ptr;
   logic                    zlen;          // granted request has size 0

   logic [1:0]              win_idx;
   logic                    win_found;
   logic [1:0]              cand;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [SIZE_WIDTH-1:0]   sel_size_raw;
   logic [SIZE_WIDTH-1:0]   sel_size;

   logic [1:0]              rr_ptr_nxt;
   logic                    zlen_nxt;
   logic [2:0]              cl_gnt_nxt;
   logic [2:0]              cl_valid_nxt;
   logic [MEM_DATA_BUS-1:0] cl_data_nxt;
   logic                    mem_req_nxt;
   logic [ADDR_WIDTH-1:0]   mem_start_addr_nxt;
   logic [SIZE_WIDTH-1:0]   mem_size_bytes_nxt;

   logic                    wdog_hit_c;

   // Round-robin pick: search rr_ptr+1, rr_ptr+2, rr_ptr (mod 3)
   always_comb begin
      win_idx   = 2'd0;
      win_found = 1'b0;
      cand      = rr_ptr;
      for (int k = 0; k < 3; k++) begin
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
         if (!win_found && cl_req[cand]) begin
            win_idx   = cand;
            win_found = 1'b1;
         end
      end
   end

   // Winner's address and clamped size
   always_comb begin
      sel_addr     = cl_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      sel_size_raw = cl_size[win_idx*SIZE_WIDTH +: SIZE_WIDTH];
      sel_size     = (sel_size_raw > SIZE_WIDTH'(MAX_BYTES_TO_RD))
                     ? SIZE_WIDTH'(MAX_BYTES_TO_RD) : sel_size_raw;
   end

`ifdef CNN_RD_ARB_WDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_cnt;

   // Trips on the WDOG_CYCLES-th cycle spent in the current ISSUE/WAIT state
   assign wdog_hit_c = ((state == S_ISSUE) || ((state == S_WAIT) && !zlen)) &&
                       (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

   // Cleared on entry to ISSUE or WAIT, counts while in either
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt <= '0;
      end else if ((state_nxt != state) &&
                   ((state_nxt == S_ISSUE) || (state_nxt == S_WAIT))) begin
         wdog_cnt <= '0;
      end else if ((state == S_ISSUE) || (state == S_WAIT)) begin
         wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
   end

   // Sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_err <= 1'b0;
      end else if (wdog_hit_c) begin
         wdog_err <= 1'b1;
      end
   end
`else
   assign wdog_hit_c = 1'b0;
   assign wdog_err   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a zero-size grant passes through WAIT for one cycle
   // so its cl_valid lands one cycle after the grant, like a real read
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (win_found) begin
               state_nxt = (sel_size == '0) ? S_WAIT : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wdog_hit_c) begin
               state_nxt = S_RELEASE;
            end else if (mem_ack) begin
               state_nxt = mem_valid ? S_RELEASE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (zlen || mem_valid || wdog_hit_c) begin
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      rr_ptr_nxt         = rr_ptr;
      zlen_nxt           = zlen;
      cl_gnt_nxt         = cl_gnt;
      cl_valid_nxt       = 3'b000;
      cl_data_nxt        = cl_data;
      mem_req_nxt        = mem_req;
      mem_start_addr_nxt = mem_start_addr;
      mem_size_bytes_nxt = mem_size_bytes;
      unique case (state)
         S_IDLE: begin
            if (win_found) begin
               cl_gnt_nxt         = 3'b001 << win_idx;
               rr_ptr_nxt         = win_idx;
               mem_start_addr_nxt = sel_addr;
               mem_size_bytes_nxt = sel_size;
               zlen_nxt           = (sel_size == '0);
               mem_req_nxt        = (sel_size != '0);
            end
         end
         S_ISSUE: begin
            if (wdog_hit_c) begin
               mem_req_nxt  = 1'b0;
               cl_valid_nxt = cl_gnt;
               cl_data_nxt  = '0;
            end else if (mem_ack) begin
               mem_req_nxt = 1'b0;
               if (mem_valid) begin
                  cl_valid_nxt = cl_gnt;
                  cl_data_nxt  = mem_data;
               end
            end
         end
         S_WAIT: begin
            if (zlen || wdog_hit_c) begin
               cl_valid_nxt = cl_gnt;
               cl_data_nxt  = '0;
            end else if (mem_valid) begin
               cl_valid_nxt = cl_gnt;
               cl_data_nxt  = mem_data;
            end
         end
         S_RELEASE: begin
            cl_gnt_nxt = 3'b000;
         end
         default: cl_gnt_nxt = 3'b000;
      endcase
   end

   // Output and context registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr         <= 2'd2;
         zlen           <= 1'b0;
         cl_gnt         <= 3'b000;
         cl_valid       <= 3'b000;
         cl_data        <= '0;
         mem_req        <= 1'b0;
         mem_start_addr <= '0;
         mem_size_bytes <= '0;
         busy           <= 1'b0;
      end else begin
         rr_ptr         <= rr_ptr_nxt;
         zlen           <= zlen_nxt;
         cl_gnt         <= cl_gnt_nxt;
         cl_valid       <= cl_valid_nxt;
         cl_data        <= cl_data_nxt;
         mem_req        <= mem_req_nxt;
         mem_start_addr <= mem_start_addr_nxt;
         mem_size_bytes <= mem_size_bytes_nxt;
         busy           <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_cnn_rd_arb.sv
// tb_cnn_rd_arb: directed bench for cnn_rd_arb. Stimulus pushes the expected
// grant and the expected client return into queues; a negedge monitor pops
// and compares them whenever the DUT presents a grant or a cl_valid pulse.
module tb_cnn_rd_arb;

   localparam int unsigned AW = 19;
   localparam int unsigned DW = 128;
   localparam int unsigned SW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      cl_req;
   logic [3*AW-1:0] cl_addr;
   logic [3*SW-1:0] cl_size;
   logic [2:0]      cl_gnt;
   logic [2:0]      cl_valid;
   logic [DW-1:0]   cl_data;
   logic            mem_req;
   logic [AW-1:0]   mem_start_addr;
   logic [SW-1:0]   mem_size_bytes;
   logic            mem_ack;
   logic            mem_valid;
   logic [DW-1:0]   mem_data;
   logic            busy;
   logic            wdog_err;

   cnn_rd_arb #(
      .ADDR_WIDTH      (AW),
      .MEM_DATA_BUS    (DW),
      .MAX_BYTES_TO_RD (20),
      .SIZE_WIDTH      (SW)
`ifdef CNN_RD_ARB_WDOG_EN
      ,
      .WDOG_CYCLES     (8)
`endif
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cl_req         (cl_req),
      .cl_addr        (cl_addr),
      .cl_size        (cl_size),
      .cl_gnt         (cl_gnt),
      .cl_valid       (cl_valid),
      .cl_data        (cl_data),
      .mem_req        (mem_req),
      .mem_start_addr (mem_start_addr),
      .mem_size_bytes (mem_size_bytes),
      .mem_ack        (mem_ack),
      .mem_valid      (mem_valid),
      .mem_data       (mem_data),
      .busy           (busy),
      .wdog_err       (wdog_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    vld;
      logic [DW-1:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [2:0] exp_gnt_q[$];
   logic [2:0] prev_gnt = 3'b000;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: grants and client returns
   always @(negedge clk) begin
      exp_t e;
      if (cl_valid != 3'b000) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_cl_valid", DW'(cl_valid), '0);
         end else begin
            e = exp_q.pop_front();
            chk("cl_valid", DW'(cl_valid), DW'(e.vld));
            chk("cl_data", cl_data, e.data);
         end
      end
      if ((cl_gnt != 3'b000) && (prev_gnt == 3'b000)) begin
         if (exp_gnt_q.size() == 0) chk("unexpected_gnt", DW'(cl_gnt), '0);
         else chk("cl_gnt", DW'(cl_gnt), DW'(exp_gnt_q.pop_front()));
      end else if ((cl_gnt != 3'b000) && (prev_gnt != 3'b000) && (cl_gnt != prev_gnt)) begin
         chk("gnt_overlap", DW'(cl_gnt), DW'(prev_gnt));
      end
      prev_gnt = cl_gnt;
   end

   task automatic set_client(input int idx, input logic [AW-1:0] a, input logic [SW-1:0] s);
      cl_addr[idx*AW +: AW] = a;
      cl_size[idx*SW +: SW] = s;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      cl_req    = 3'b000;
      mem_ack   = 1'b0;
      mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for mem_req; returns negedges waited
   task automatic wait_mem_req(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!mem_req && lat < 40);
      chk("mem_req_seen", DW'(mem_req), DW'(1));
   endtask

   // Memory side of one read: checks the request, then acks and returns data
   task automatic serve_mem(input logic [2:0] eg, input logic [AW-1:0] ea, input logic [SW-1:0] es,
                            input int ack_wait, input int val_gap, input logic [DW-1:0] d,
                            output int lat);
      wait_mem_req(lat);
      chk("mem_start_addr", DW'(mem_start_addr), DW'(ea));
      chk("mem_size_bytes", DW'(mem_size_bytes), DW'(es));
      chk("gnt_during_req", DW'(cl_gnt), DW'(eg));
      repeat (ack_wait) @(negedge clk);
      mem_ack = 1'b1;
      if (val_gap == 0) begin
         mem_valid = 1'b1;
         mem_data  = d;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_valid = 1'b0;
      if (val_gap > 0) begin
         chk("mem_req_dropped", DW'(mem_req), '0);
         repeat (val_gap - 1) @(negedge clk);
         mem_valid = 1'b1;
         mem_data  = d;
         @(negedge clk);
         mem_valid = 1'b0;
      end
   endtask

   initial begin
      int            lat;
      logic [DW-1:0] d;
      logic [AW-1:0] a3[3];
      logic [SW-1:0] s3[3];
      rst = 1'b1; cl_req = '0; cl_addr = '0; cl_size = '0;
      mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cl_gnt", DW'(cl_gnt), '0);
      chk("rst_cl_valid", DW'(cl_valid), '0);
      chk("rst_mem_req", DW'(mem_req), '0);
      chk("rst_busy", DW'(busy), '0);
      chk("rst_wdog_err", DW'(wdog_err), '0);
      chk("rst_cl_data", cl_data, '0);
      rst = 1'b0;

      // 1: single picture read, ack at +2, data at +4
      d = {4{32'hDEAD_BEEF}};
      set_client(0, 19'h00100, 5'd4);
      exp_gnt_q.push_back(3'b001);
      exp_q.push_back('{3'b001, d});
      cl_req = 3'b001;
      serve_mem(3'b001, 19'h00100, 5'd4, 1, 2, d, lat);
      chk("t1_req_latency", DW'(lat), DW'(1));
      chk("t1_cl_valid_inline", DW'(cl_valid), DW'(3'b001));
      cl_req = 3'b000;
      @(negedge clk);
      chk("t1_busy_low", DW'(busy), '0);

      // 2: all clients requesting continuously -> 0,1,2,0,1,2
      do_reset();
      a3[0] = 19'h00200; a3[1] = 19'h00300; a3[2] = 19'h00400;
      s3[0] = 5'd8;      s3[1] = 5'd12;     s3[2] = 5'd16;
      for (int c = 0; c < 3; c++) set_client(c, a3[c], s3[c]);
      for (int i = 0; i < 6; i++) begin
         exp_gnt_q.push_back(3'b001 << (i % 3));
         exp_q.push_back('{3'b001 << (i % 3), {4{32'hC0DE_0000 | 32'(i)}}});
      end
      cl_req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         serve_mem(3'b001 << (i % 3), a3[i % 3], s3[i % 3], 1, 1,
                   {4{32'hC0DE_0000 | 32'(i)}}, lat);
      end
      cl_req = 3'b000;
      repeat (2) @(negedge clk);

      // 3: zero-size bias request: no memory access, cl_valid two cycles later
      set_client(2, 19'h00440, 5'd0);
      exp_gnt_q.push_back(3'b100);
      exp_q.push_back('{3'b100, '0});
      cl_req = 3'b100;
      @(negedge clk);
      chk("t3_no_valid_yet", DW'(cl_valid), '0);
      chk("t3_no_mem_req_c1", DW'(mem_req), '0);
      @(negedge clk);
      chk("t3_cl_valid", DW'(cl_valid), DW'(3'b100));
      chk("t3_no_mem_req_c2", DW'(mem_req), '0);
      cl_req = 3'b000;
      repeat (2) @(negedge clk);

      // 4: oversize weights request, ack and data together
      d = {2{64'h0123_4567_89AB_CDEF}};
      set_client(1, 19'h005A0, 5'd31);
      exp_gnt_q.push_back(3'b010);
      exp_q.push_back('{3'b010, d});
      cl_req = 3'b010;
      serve_mem(3'b010, 19'h005A0, 5'd20, 1, 0, d, lat);
      chk("t4_cl_valid_next", DW'(cl_valid), DW'(3'b010));
      cl_req = 3'b000;
      repeat (2) @(negedge clk);

      // 5: reset in WAIT, then a late mem_valid is ignored
      set_client(0, 19'h00700, 5'd2);
      exp_gnt_q.push_back(3'b001);
      cl_req = 3'b001;
      wait_mem_req(lat);
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("t5_in_wait", DW'(busy), DW'(1));
      @(negedge clk);
      rst = 1'b1;
      cl_req = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mem_valid = 1'b1;
      mem_data  = {4{32'hBAD0_BAD0}};
      @(negedge clk);
      mem_valid = 1'b0;
      chk("t5_cl_valid", DW'(cl_valid), '0);
      chk("t5_cl_gnt", DW'(cl_gnt), '0);
      chk("t5_mem_req", DW'(mem_req), '0);
      chk("t5_busy", DW'(busy), '0);
      chk("t5_cl_data", cl_data, '0);
      chk("t5_mem_addr", DW'(mem_start_addr), '0);
      d = {4{32'h5555_AAAA}};
      set_client(1, 19'h00120, 5'd3);
      exp_gnt_q.push_back(3'b010);
      exp_q.push_back('{3'b010, d});
      cl_req = 3'b010;
      serve_mem(3'b010, 19'h00120, 5'd3, 1, 2, d, lat);
      cl_req = 3'b000;
      repeat (2) @(negedge clk);

      // 6: memory acks but never returns data
      set_client(0, 19'h000AA, 5'd6);
      exp_gnt_q.push_back(3'b001);
      cl_req = 3'b001;
      wait_mem_req(lat);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
`ifdef CNN_RD_ARB_WDOG_EN
      exp_q.push_back('{3'b001, '0});
      repeat (7) @(negedge clk);
      chk("t6_no_err_early", DW'(wdog_err), '0);
      chk("t6_no_valid_early", DW'(cl_valid), '0);
      @(negedge clk);
      chk("t6_wdog_err", DW'(wdog_err), DW'(1));
      chk("t6_cl_valid", DW'(cl_valid), DW'(3'b001));
      cl_req = 3'b000;
      @(negedge clk);
      chk("t6_idle", DW'(busy), '0);
      chk("t6_sticky", DW'(wdog_err), DW'(1));
      chk("t6_mem_req", DW'(mem_req), '0);
`else
      repeat (20) @(negedge clk);
      chk("t6_still_busy", DW'(busy), DW'(1));
      chk("t6_gnt_held", DW'(cl_gnt), DW'(3'b001));
      chk("t6_no_wdog", DW'(wdog_err), '0);
      chk("t6_mem_req", DW'(mem_req), '0);
      do_reset();
      @(negedge clk);
      chk("t6_reset_idle", DW'(busy), '0);
`endif

      repeat (3) @(negedge clk);
      chk("exp_q_drained", DW'(exp_q.size()), '0);
      chk("exp_gnt_q_drained", DW'(exp_gnt_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
